fifo_write_arbiter: RTL
=======================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the single write side of the async FIFO (insert/flush/full) among NUM_REQ producers in the write clock domain.
//  Round-robin arbitration with bounded bursts; owns FIFO flush sequencing.
//  Sits directly in front of the FIFO write controller: drives its insert, flush and data, and obeys its full.
// PARAMETERS
//  NUM_REQ    4  number of requesting producers (2..8)
//  WIDTH      8  data word width
//  MAX_BURST  4  max accepted beats per grant before forced handover (1..16)
// PORTS
//  clk_in      in   1                write-domain clock; all logic on rising edge
//  reset       in   1                synchronous, active-high reset
//  req         in   NUM_REQ          per-producer request, level; held while data valid
//  req_data    in   NUM_REQ*WIDTH    producer i word at [i*WIDTH +: WIDTH]
//  flush_req   in   1                request FIFO flush (single-cycle pulse or level)
//  fifo_full   in   1                full flag from FIFO write controller
//  grant       out  NUM_REQ          one-hot; beat accepted from producer i this cycle
//  fifo_insert out  1                write strobe to FIFO write controller
//  fifo_data   out  WIDTH            word presented with fifo_insert
//  fifo_flush  out  1                one-cycle flush pulse to FIFO write controller
//  owner       out  clog2(NUM_REQ)   current owner index (valid in BURST/STALL)
//  busy        out  1                state != IDLE
// BEHAVIOUR
//  - Reset (reset=1 at edge): state=IDLE, owner=0, rr_ptr=0 (req[0] highest priority), beat_cnt=0, fifo_flush=0.
//    grant, fifo_insert and fifo_data are 0 via state decode. Reset mid-burst aborts the burst; no partial beat.
//  - States: IDLE, BURST, STALL, FLUSH.
//  - IDLE: if flush_req -> FLUSH. Else if |req: owner = first requester at or after rr_ptr (wrapping) -> BURST, beat_cnt=0.
//    Grant latency: first beat is accepted 1 cycle after req is seen in IDLE.
//  - BURST: accept = req[owner] & !fifo_full. Combinational outputs from registered state:
//    fifo_insert=accept, grant[owner]=accept, fifo_data=req_data[owner].
//    - Producers advance data only on grant.
//    - On accept: beat_cnt++.
//    - Exit to IDLE with rr_ptr=owner+1 (mod NUM_REQ) when either:
//      - accept & beat_cnt==MAX_BURST-1, or
//      - !req[owner].
//    - Else if fifo_full & req[owner] -> STALL.
//    - One bubble cycle (IDLE) on every handover.
//  - STALL: no insert, no grant; beat_cnt frozen. !fifo_full -> BURST; !req[owner] -> IDLE (rr_ptr advances).
//  - FLUSH: fifo_flush=1 for exactly one cycle, no inserts; then -> IDLE with rr_ptr=0.
//    - flush_req in BURST/STALL -> FLUSH next edge. It wins over accept in the same cycle: no insert that cycle.
//  - fifo_insert never asserted while fifo_full=1; grant always equals fifo_insert on the owner bit; grant is never multi-hot.
//  - Simultaneous requests: strict rotation. A lone requester re-wins after the handover bubble (no starvation, no lockout).
//  - beat_cnt width clog2(MAX_BURST)+1; never wraps (bounded by exit rule).
// CONFIGURATION
//  - FIFO_WR_ARB_STATS_EN defined:
//    - adds output stat_beats [NUM_REQ*16]: per-producer 16-bit saturating counts of accepted beats.
//    - adds output stat_stall [16]: saturating count of STALL cycles.
//    - All counters cleared by reset and by FLUSH.
//  - Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package fifo_arb_pkg: state encoding (IDLE=2'b00, BURST=2'b01, STALL=2'b11, FLUSH=2'b10), STAT_W=16.
//  - Sub-module rr_priority_select: combinational rotate + priority encode (req, rr_ptr -> hit, index).
//    No state; instantiated once.
// TESTING
//  1. Reset, req=4'b0001, full=0, MAX_BURST=4 -> grant[0] on cycles 2-5, IDLE cycle 6, grant[0] resumes cycle 7.
//  2. req=4'b1111 held -> bursts of 4 in order 0,1,2,3,0 with one bubble between each; fifo_data matches owner word.
//  3. Owner 2 in BURST, fifo_full=1 for 5 cycles -> STALL, fifo_insert=0, beat_cnt frozen; full drops -> remaining beats complete the burst of 4.
//  4. req[1] drops after 2 beats while req[3]=1 -> IDLE, then owner=3, rr_ptr=2 at handover.
//  5. flush_req pulse mid-burst with accept pending -> no insert that cycle, fifo_flush=1 one cycle, next grant goes to lowest requesting index.
//  6. FIFO_WR_ARB_STATS_EN: 70000 beats from producer 0 -> stat_beats[15:0] saturates at 16'hFFFF; reset clears it to 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding, statistics width and a
// saturating increment helper.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StBurst = 2'b01,
      StStall = 2'b11,
      StFlush = 2'b10
   } arb_state_e;

   localparam int unsigned STAT_W = 16;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
      return (val == {STAT_W{1'b1}}) ? val : val + STAT_W'(1);
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: the first asserted request at or after rr_ptr, wrapping
// around through index NUM_REQ-1 back to 0.
module rr_priority_select #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               hit,
   output logic [IDX_W-1:0]   index
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   always_comb begin
      hit   = 1'b0;
      index = '0;
      sum   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         // rr_ptr and i are both below NUM_REQ, so one conditional subtract gives the modulo
         sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (!hit && req[cand]) begin
            hit   = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the FIFO write port among NUM_REQ producers, with
// flush sequencing. Define FIFO_WR_ARB_STATS_EN to add saturating beat/stall statistics outputs.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4,
   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk_in,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   input  logic                     flush_req,
   input  logic                     fifo_full,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     fifo_insert,
   output logic [WIDTH-1:0]         fifo_data,
   output logic                     fifo_flush,
   output logic [IDX_W-1:0]         owner,
   output logic                     busy
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0] stat_beats,
   output logic [STAT_W-1:0]         stat_stall
`endif
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

   arb_state_e       state_q;
   logic [IDX_W-1:0] owner_q;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [CNT_W-1:0] beat_cnt_q;
   logic             fifo_flush_q;

   logic             sel_hit;
   logic [IDX_W-1:0] sel_idx;
   logic             in_burst;
   logic             owner_req;
   logic             accept;
   logic             last_beat;
   logic [IDX_W-1:0] owner_next;

   rr_priority_select #(
      .NUM_REQ (NUM_REQ)
   ) u_select (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .hit    (sel_hit),
      .index  (sel_idx)
   );

   assign in_burst   = (state_q == StBurst);
   assign owner_req  = req[owner_q];
   // A pending flush pre-empts the beat in the same cycle
   assign accept     = in_burst & owner_req & ~fifo_full & ~flush_req;
   assign last_beat  = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
   assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q      <= StIdle;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         beat_cnt_q   <= '0;
         fifo_flush_q <= 1'b0;
      end else begin
         fifo_flush_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (flush_req) begin
                  state_q      <= StFlush;
                  fifo_flush_q <= 1'b1;
               end else if (sel_hit) begin
                  state_q    <= StBurst;
                  owner_q    <= sel_idx;
                  beat_cnt_q <= '0;
               end
            end
            StBurst: begin
               if (flush_req) begin
                  state_q      <= StFlush;
                  fifo_flush_q <= 1'b1;
               end else if ((accept && last_beat) || !owner_req) begin
                  state_q    <= StIdle;
                  rr_ptr_q   <= owner_next;
                  beat_cnt_q <= '0;
               end else begin
                  if (accept) begin
                     beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                  end
                  if (fifo_full) begin
                     state_q <= StStall;
                  end
               end
            end
            StStall: begin
               if (flush_req) begin
                  state_q      <= StFlush;
                  fifo_flush_q <= 1'b1;
               end else if (!owner_req) begin
                  state_q    <= StIdle;
                  rr_ptr_q   <= owner_next;
                  beat_cnt_q <= '0;
               end else if (!fifo_full) begin
                  state_q <= StBurst;
               end
            end
            StFlush: begin
               state_q    <= StIdle;
               rr_ptr_q   <= '0;
               beat_cnt_q <= '0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      grant = '0;
      if (accept) begin
         grant[owner_q] = 1'b1;
      end
   end

   assign fifo_insert = accept;
   assign fifo_data   = in_burst ? req_data[owner_q*WIDTH +: WIDTH] : '0;
   assign fifo_flush  = fifo_flush_q;
   assign owner       = owner_q;
   assign busy        = (state_q != StIdle);

`ifdef FIFO_WR_ARB_STATS_EN
   logic [NUM_REQ-1:0][STAT_W-1:0] beats_q;
   logic [STAT_W-1:0]              stall_q;

   always_ff @(posedge clk_in) begin
      if (reset || state_q == StFlush) begin
         beats_q <= '0;
         stall_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
               beats_q[i] <= sat_inc(beats_q[i]);
            end
         end
         if (state_q == StStall) begin
            stall_q <= sat_inc(stall_q);
         end
      end
   end

   assign stat_beats = beats_q;
   assign stat_stall = stall_q;
`endif

endmodule
